// File: rtl/sram2axi_bridge_mp_if.sv
// Bus bundle between NPORT SRAM-like requesters and one single-beat AXI master port.
// The bridge takes the slave modport; requesters plus the AXI slave take the master modport.
interface sram2axi_bridge_mp_if #(
    parameter int NPORT = 2
);
    logic [NPORT-1:0]    sram_req;
    logic [NPORT-1:0]    sram_wr;
    logic [2*NPORT-1:0]  sram_size;
    logic [4*NPORT-1:0]  sram_wstrb;
    logic [32*NPORT-1:0] sram_addr;
    logic [32*NPORT-1:0] sram_wdata;
    logic [NPORT-1:0]    sram_addr_ok;
    logic [NPORT-1:0]    sram_data_ok;
    logic [32*NPORT-1:0] sram_rdata;

    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;

    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    // Every AXI channel moves a beat on a cycle where valid && ready are both high at the clock edge.
    modport slave (
        input  sram_req, sram_wr, sram_size, sram_wstrb, sram_addr, sram_wdata,
        output sram_addr_ok, sram_data_ok, sram_rdata,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport master (
        output sram_req, sram_wr, sram_size, sram_wstrb, sram_addr, sram_wdata,
        input  sram_addr_ok, sram_data_ok, sram_rdata,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/sram2axi_bridge_mp.sv
// Multi-port SRAM-like to AXI single-beat bridge with round-robin accept and per-port read tracking.
// Optional macro SRAM2AXI_RAW_CHECK_EN: block reads only on a word-address match with the pending write.
module sram2axi_bridge_mp #(
    parameter int NPORT   = 2,
    parameter int RD_OUTS = 2
) (
    input logic                  clk,
    input logic                  reset,
    sram2axi_bridge_mp_if.slave  bus
);
    logic [2:0]  cnt_q [NPORT];
    logic [1:0]  rr_q, rr_d;
    logic        arvalid_q, awvalid_q, wvalid_q, wr_pend_q;
    logic [31:0] araddr_q, awaddr_q, wdata_q;
    logic [2:0]  arsize_q, awsize_q;
    logic [3:0]  arid_q, awid_q, wstrb_q;

    logic [NPORT-1:0] raw_block, rd_elig, wr_elig, elig;
    logic [NPORT-1:0] gnt_oh, data_ok, cnt_inc, cnt_dec;
    logic             acc, acc_wr;
    logic [1:0]       gnt;
    logic [31:0]      sel_addr, sel_wdata;
    logic [3:0]       sel_wstrb;
    logic [1:0]       sel_size;
    logic             unused_resp;

    always_comb begin
        for (int i = 0; i < NPORT; i++) begin
`ifdef SRAM2AXI_RAW_CHECK_EN
            raw_block[i] = wr_pend_q && (bus.sram_addr[i*32+2 +: 30] == awaddr_q[31:2]);
`else
            raw_block[i] = wr_pend_q;
`endif
            rd_elig[i] = (!arvalid_q || bus.arready) && (cnt_q[i] < 3'(RD_OUTS))
                         && !(wr_pend_q && (awid_q == 4'(i))) && !raw_block[i];
            wr_elig[i] = !wr_pend_q && (cnt_q[i] == 3'd0);
            elig[i]    = bus.sram_req[i] && (bus.sram_wr[i] ? wr_elig[i] : rd_elig[i]);
        end
    end

    // Round-robin: first eligible requester at or above the pointer, wrapping at NPORT-1.
    always_comb begin
        acc       = 1'b0;
        acc_wr    = 1'b0;
        gnt       = 2'd0;
        gnt_oh    = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wstrb = '0;
        sel_size  = '0;
        for (int k = 0; k < NPORT; k++) begin
            for (int i = 0; i < NPORT; i++) begin
                if (!acc && elig[i] && (((int'(rr_q) + k) % NPORT) == i)) begin
                    acc       = 1'b1;
                    acc_wr    = bus.sram_wr[i];
                    gnt       = 2'(i);
                    gnt_oh[i] = 1'b1;
                    sel_addr  = bus.sram_addr[i*32 +: 32];
                    sel_wdata = bus.sram_wdata[i*32 +: 32];
                    sel_wstrb = bus.sram_wstrb[i*4 +: 4];
                    sel_size  = bus.sram_size[i*2 +: 2];
                end
            end
        end
        if (reset) begin
            acc    = 1'b0;
            gnt_oh = '0;
        end
        rr_d = (int'(gnt) == NPORT - 1) ? 2'd0 : gnt + 2'd1;
    end

    always_comb begin
        for (int i = 0; i < NPORT; i++) begin
            data_ok[i] = !reset && ((bus.rvalid && (bus.rid == 4'(i)))
                                    || (bus.bvalid && (bus.bid == 4'(i))));
            cnt_inc[i] = acc && !acc_wr && gnt_oh[i];
            cnt_dec[i] = bus.rvalid && (bus.rid == 4'(i)) && (cnt_q[i] != 3'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            arvalid_q <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            wr_pend_q <= 1'b0;
            rr_q      <= 2'd0;
            for (int i = 0; i < NPORT; i++) cnt_q[i] <= 3'd0;
        end else begin
            if (bus.arready) arvalid_q <= 1'b0;
            if (bus.awready) awvalid_q <= 1'b0;
            if (bus.wready)  wvalid_q  <= 1'b0;
            if (bus.bvalid)  wr_pend_q <= 1'b0;
            if (acc) begin
                rr_q <= rr_d;
                if (acc_wr) begin
                    awvalid_q <= 1'b1;
                    wvalid_q  <= 1'b1;
                    wr_pend_q <= 1'b1;
                    awaddr_q  <= sel_addr;
                    awsize_q  <= {1'b0, sel_size};
                    awid_q    <= 4'(gnt);
                    wdata_q   <= sel_wdata;
                    wstrb_q   <= sel_wstrb;
                end else begin
                    arvalid_q <= 1'b1;
                    araddr_q  <= sel_addr;
                    arsize_q  <= {1'b0, sel_size};
                    arid_q    <= 4'(gnt);
                end
            end
            for (int i = 0; i < NPORT; i++) begin
                if (cnt_inc[i] && !cnt_dec[i])      cnt_q[i] <= cnt_q[i] + 3'd1;
                else if (cnt_dec[i] && !cnt_inc[i]) cnt_q[i] <= cnt_q[i] - 3'd1;
            end
        end
    end

    assign bus.sram_addr_ok = gnt_oh;
    assign bus.sram_data_ok = data_ok;
    assign bus.sram_rdata   = {NPORT{bus.rdata}};

    assign bus.arid    = arid_q;
    assign bus.araddr  = araddr_q;
    assign bus.arlen   = 8'd0;
    assign bus.arsize  = arsize_q;
    assign bus.arburst = 2'b01;
    assign bus.arlock  = 1'b0;
    assign bus.arcache = 4'd0;
    assign bus.arprot  = 3'd0;
    assign bus.arvalid = arvalid_q;
    assign bus.rready  = 1'b1;

    assign bus.awid    = awid_q;
    assign bus.awaddr  = awaddr_q;
    assign bus.awlen   = 8'd0;
    assign bus.awsize  = awsize_q;
    assign bus.awburst = 2'b01;
    assign bus.awlock  = 1'b0;
    assign bus.awcache = 4'd0;
    assign bus.awprot  = 3'd0;
    assign bus.awvalid = awvalid_q;
    assign bus.wid     = awid_q;
    assign bus.wdata   = wdata_q;
    assign bus.wstrb   = wstrb_q;
    assign bus.wlast   = 1'b1;
    assign bus.wvalid  = wvalid_q;
    assign bus.bready  = 1'b1;

    assign unused_resp = ^{bus.rresp, bus.rlast, bus.bresp};
endmodule

// File: tb/tb_sram2axi_bridge_mp.sv
// Directed bench for sram2axi_bridge_mp: transaction-level reference model checked every cycle,
// plus literal expectations for the documented scenarios (honours SRAM2AXI_RAW_CHECK_EN).
module tb_sram2axi_bridge_mp;
  localparam int NPORT   = 2;
  localparam int RD_OUTS = 2;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  sram2axi_bridge_mp_if #(.NPORT(NPORT)) bus();

  sram2axi_bridge_mp #(.NPORT(NPORT), .RD_OUTS(RD_OUTS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  int          m_rr;
  int          m_cnt [NPORT];
  bit          m_wpend;
  int          m_wport;
  bit          m_arv, m_awv, m_wv;
  logic [31:0] m_araddr, m_awaddr, m_wdata;
  logic [2:0]  m_arsize, m_awsize;
  logic [3:0]  m_wstrb;
  int          m_arid;

  function automatic bit may_read(input int p);
    logic [31:0] a;
    a = bus.sram_addr[p*32 +: 32];
    if (m_arv && !bus.arready) return 1'b0;
    if (m_cnt[p] >= RD_OUTS) return 1'b0;
    if (m_wpend && m_wport == p) return 1'b0;
`ifdef SRAM2AXI_RAW_CHECK_EN
    if (m_wpend && (a >> 2) == (m_awaddr >> 2)) return 1'b0;
`else
    if (m_wpend) return 1'b0;
`endif
    return 1'b1;
  endfunction

  function automatic bit may_write(input int p);
    return !m_wpend && m_cnt[p] == 0;
  endfunction

  always @(negedge clk) begin : compare
    int g;
    int p;
    logic [NPORT-1:0] e_ok;
    logic [NPORT-1:0] e_dok;
    g = -1;
    e_ok = '0;
    e_dok = '0;
    if (!reset) begin
      for (int k = 0; k < NPORT; k++) begin
        p = (m_rr + k) % NPORT;
        if (g < 0 && bus.sram_req[p] && (bus.sram_wr[p] ? may_write(p) : may_read(p))) g = p;
      end
      if (g >= 0) e_ok[g] = 1'b1;
      for (int q = 0; q < NPORT; q++)
        e_dok[q] = (bus.rvalid && bus.rid == q) || (bus.bvalid && bus.bid == q);
    end
    chk("addr_ok", bus.sram_addr_ok, e_ok);
    chk("data_ok", bus.sram_data_ok, e_dok);
    for (int q = 0; q < NPORT; q++)
      if (!reset && bus.rvalid && bus.rid == q) chk("rdata", bus.sram_rdata[q*32 +: 32], bus.rdata);
    chk("arvalid", bus.arvalid, m_arv);
    if (m_arv) begin
      chk("araddr", bus.araddr, m_araddr);
      chk("arsize", bus.arsize, m_arsize);
      chk("arid", bus.arid, m_arid);
    end
    chk("awvalid", bus.awvalid, m_awv);
    chk("wvalid", bus.wvalid, m_wv);
    if (m_awv) begin
      chk("awaddr", bus.awaddr, m_awaddr);
      chk("awsize", bus.awsize, m_awsize);
      chk("awid", bus.awid, m_wport);
    end
    if (m_wv) begin
      chk("wdata", bus.wdata, m_wdata);
      chk("wstrb", bus.wstrb, m_wstrb);
      chk("wid", bus.wid, m_wport);
      chk("wlast", bus.wlast, 1);
    end
    chk("rready_bready", {bus.rready, bus.bready}, 2'b11);
    chk("ar_const", {bus.arlen, bus.arburst, bus.arlock}, {8'd0, 2'b01, 1'b0});

    // advance model to the state after the coming rising edge
    if (reset) begin
      m_rr = 0; m_wpend = 0; m_arv = 0; m_awv = 0; m_wv = 0;
      for (int q = 0; q < NPORT; q++) m_cnt[q] = 0;
    end else begin
      if (bus.arready) m_arv = 0;
      if (bus.awready) m_awv = 0;
      if (bus.wready) m_wv = 0;
      if (bus.bvalid) m_wpend = 0;
      if (bus.rvalid && bus.rid < NPORT && m_cnt[bus.rid] > 0) m_cnt[bus.rid]--;
      if (g >= 0) begin
        m_rr = (g + 1) % NPORT;
        if (bus.sram_wr[g]) begin
          m_wpend = 1; m_wport = g; m_awv = 1; m_wv = 1;
          m_awaddr = bus.sram_addr[g*32 +: 32];
          m_awsize = {1'b0, bus.sram_size[g*2 +: 2]};
          m_wdata  = bus.sram_wdata[g*32 +: 32];
          m_wstrb  = bus.sram_wstrb[g*4 +: 4];
        end else begin
          m_arv = 1; m_arid = g; m_cnt[g]++;
          m_araddr = bus.sram_addr[g*32 +: 32];
          m_arsize = {1'b0, bus.sram_size[g*2 +: 2]};
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.sram_req = '0;
    bus.rvalid   = 1'b0;
    bus.bvalid   = 1'b0;
  endtask

  task automatic set_req(input int p, input bit wr, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] strb, input logic [1:0] size);
    bus.sram_req[p]            = 1'b1;
    bus.sram_wr[p]             = wr;
    bus.sram_addr[p*32 +: 32]  = addr;
    bus.sram_wdata[p*32 +: 32] = data;
    bus.sram_wstrb[p*4 +: 4]   = strb;
    bus.sram_size[p*2 +: 2]    = size;
  endtask

  task automatic r_beat(input logic [3:0] id, input logic [31:0] data);
    bus.rvalid = 1'b1;
    bus.rid    = id;
    bus.rdata  = data;
  endtask

  task automatic b_beat(input logic [3:0] id);
    bus.bvalid = 1'b1;
    bus.bid    = id;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  logic [NPORT-1:0] grants [6];
  logic [NPORT-1:0] exp_grants [6];
  bit got, b_sent;
  int acc_at;

  initial begin
    reset = 1'b1;
    bus.sram_req = '1; bus.sram_wr = '0; bus.sram_size = '0; bus.sram_wstrb = '0;
    bus.sram_addr = '0; bus.sram_wdata = '0;
    bus.arready = 1'b1; bus.awready = 1'b1; bus.wready = 1'b1;
    bus.rid = '0; bus.rdata = '0; bus.rresp = '0; bus.rlast = 1'b1; bus.rvalid = 1'b0;
    bus.bid = '0; bus.bresp = '0; bus.bvalid = 1'b0;
    cyc(); cyc();
    #1;
    chk("rst_addr_ok_gated", bus.sram_addr_ok, 2'b00);
    chk("rst_valids", {bus.arvalid, bus.awvalid, bus.wvalid}, 3'b000);
    reset = 1'b0;
    idle();

    // single read on port 0
    cyc(); set_req(0, 0, 32'h1000, 32'h0, 4'hF, 2'd2);
    #1 chk("t1_addr_ok", bus.sram_addr_ok, 2'b01);
    cyc(); idle();
    #1 chk("t1_arvalid", bus.arvalid, 1'b1);
    chk("t1_araddr", bus.araddr, 32'h1000);
    chk("t1_arsize", bus.arsize, 3'd2);
    chk("t1_arid", bus.arid, 4'd0);
    cyc();
    #1 chk("t1_arvalid_drop", bus.arvalid, 1'b0);
    cyc(); r_beat(4'd0, 32'hDEADBEEF);
    #1 chk("t1_data_ok", bus.sram_data_ok, 2'b01);
    chk("t1_rdata0", bus.sram_rdata[31:0], 32'hDEADBEEF);
    cyc(); idle();
    #1 chk("t1_data_ok_pulse", bus.sram_data_ok, 2'b00);

    // continuous reads on both ports: alternation and RD_OUTS stall
    do_reset();
    exp_grants = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b00, 2'b00};
    set_req(0, 0, 32'h100, 32'h0, 4'hF, 2'd2);
    set_req(1, 0, 32'h200, 32'h0, 4'hF, 2'd1);
    for (int c = 0; c < 6; c++) begin
      #1 grants[c] = bus.sram_addr_ok;
      cyc();
    end
    for (int c = 0; c < 6; c++) chk($sformatf("t2_grant%0d", c), grants[c], exp_grants[c]);
    r_beat(4'd0, 32'h0BAD_F00D);
    #1 chk("t2_stall_during_r", bus.sram_addr_ok, 2'b00);
    cyc(); bus.rvalid = 1'b0;
    #1 chk("t2_regrant_after_r", bus.sram_addr_ok, 2'b01);
    cyc(); idle();
    for (int c = 0; c < 4; c++) begin
      r_beat(4'(c % 2), $urandom);
      cyc();
    end
    idle();

    // write with delayed awready
    bus.awready = 1'b0;
    set_req(1, 1, 32'h2000, 32'h12345678, 4'hF, 2'd2);
    #1 chk("t3_addr_ok", bus.sram_addr_ok, 2'b10);
    cyc(); idle();
    #1 chk("t3_aw_w_valid", {bus.awvalid, bus.wvalid}, 2'b11);
    chk("t3_awaddr", bus.awaddr, 32'h2000);
    chk("t3_wdata", bus.wdata, 32'h12345678);
    chk("t3_ids", {bus.awid, bus.wid}, 8'h11);
    cyc();
    #1 chk("t3_w_dropped", {bus.awvalid, bus.wvalid}, 2'b10);
    cyc(); bus.awready = 1'b1;
    #1 chk("t3_aw_held3", bus.awvalid, 1'b1);
    cyc(); b_beat(4'd1);
    #1 chk("t3_aw_dropped", bus.awvalid, 1'b0);
    chk("t3_b_data_ok", bus.sram_data_ok, 2'b10);
    cyc(); idle();

    // read-after-write hazard, different word then same word
    set_req(1, 1, 32'h3000, 32'hA5A5A5A5, 4'hF, 2'd2);
    #1 chk("t4_wr_accept", bus.sram_addr_ok, 2'b10);
    cyc(); idle(); set_req(0, 0, 32'h3004, 32'h0, 4'hF, 2'd2);
    got = 0; b_sent = 0; acc_at = -1;
    for (int i = 0; i < 6; i++) begin
      if (!got) begin
        bus.bvalid = (i == 2);
        bus.bid = 4'd1;
        if (i == 2) b_sent = 1;
        #1 if (bus.sram_addr_ok[0]) begin got = 1; acc_at = i; end
        cyc();
      end
    end
    idle();
`ifdef SRAM2AXI_RAW_CHECK_EN
    chk("t4_diff_word_accept_cycle", acc_at, 0);
`else
    chk("t4_diff_word_accept_cycle", acc_at, 3);
`endif
    if (!b_sent) b_beat(4'd1);
    cyc(); idle(); r_beat(4'd0, 32'h3004_0000);
    cyc(); idle();
    set_req(1, 1, 32'h3000, 32'h5A5A5A5A, 4'hF, 2'd2);
    #1 chk("t4_wr2_accept", bus.sram_addr_ok, 2'b10);
    cyc(); idle(); set_req(0, 0, 32'h3000, 32'h0, 4'hF, 2'd2);
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("t4_same_word_stall%0d", i), bus.sram_addr_ok, 2'b00);
      cyc();
    end
    b_beat(4'd1);
    #1 chk("t4_stall_on_b", bus.sram_addr_ok, 2'b00);
    cyc(); bus.bvalid = 1'b0;
    #1 chk("t4_accept_after_b", bus.sram_addr_ok, 2'b01);
    cyc(); idle();
    cyc(); r_beat(4'd0, 32'h3000_0000);
    cyc(); idle();

    // simultaneous R and B beats
    set_req(0, 0, 32'h4000, 32'h0, 4'hF, 2'd2);
    #1 chk("t5_rd_accept", bus.sram_addr_ok, 2'b01);
    cyc(); idle(); set_req(1, 1, 32'h5000, 32'h0000_00EE, 4'h1, 2'd0);
    #1 chk("t5_wr_accept", bus.sram_addr_ok, 2'b10);
    cyc(); idle();
    cyc(); r_beat(4'd0, 32'hCAFEF00D); b_beat(4'd1);
    #1 chk("t5_both_data_ok", bus.sram_data_ok, 2'b11);
    chk("t5_rdata0", bus.sram_rdata[31:0], 32'hCAFEF00D);
    cyc(); idle();

    // reset while a read is in flight
    bus.arready = 1'b0;
    set_req(0, 0, 32'h6000, 32'h0, 4'hF, 2'd2);
    #1 chk("t6_rd_accept", bus.sram_addr_ok, 2'b01);
    cyc(); idle(); reset = 1'b1;
    #1 chk("t6_arvalid_before_reset", bus.arvalid, 1'b1);
    cyc(); reset = 1'b0; bus.arready = 1'b1;
    set_req(0, 1, 32'h7000, 32'h0000BEEF, 4'h3, 2'd1);
    #1 chk("t6_arvalid_cleared", bus.arvalid, 1'b0);
    chk("t6_write_after_reset", bus.sram_addr_ok, 2'b01);
    cyc(); idle();
    #1 chk("t6_awsize", bus.awsize, 3'd1);
    chk("t6_wstrb", bus.wstrb, 4'h3);
    cyc(); b_beat(4'd0);
    #1 chk("t6_b_data_ok", bus.sram_data_ok, 2'b01);
    cyc(); idle();
    cyc(); cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: got timeout, want completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sram2axi_bridge_mp.md
SRAM2AXI_BRIDGE_MP -- requirements
Module: sram2axi_bridge_mp

Interface
REQ-001 SHALL have parameter NPORT, default 2, number of SRAM-like request ports (1..4; port index i is driven as the AXI ID).
REQ-002 SHALL have parameter RD_OUTS, default 2, maximum outstanding reads per port (1..7).
REQ-003 SHALL have one clock, clk; reset is synchronous and active-high, named reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 sram_req  input  NPORT  per-port request valid.
REQ-007 sram_wr  input  NPORT  per-port 1=write, 0=read.
REQ-008 sram_size  input  2*NPORT  per-port byte count code, 0=1B, 1=2B, 2=4B.
REQ-009 sram_wstrb  input  4*NPORT  per-port byte enables.
REQ-010 sram_addr  input  32*NPORT  per-port address.
REQ-011 sram_wdata  input  32*NPORT  per-port write data.
REQ-012 sram_addr_ok  output  NPORT  request accepted this cycle.
REQ-013 sram_data_ok  output  NPORT  read data valid, or write complete.
REQ-014 sram_rdata  output  32*NPORT  per-port read data, valid only with data_ok.
REQ-015 AR channel: arid[3:0], araddr[31:0], arsize[2:0], arvalid out; arready in; arlen=0, arburst=2'b01, arlock=0, arcache=0, arprot=0 constant outputs.
REQ-016 R channel: rid[3:0], rdata[31:0], rresp[1:0], rlast, rvalid in; rready out.
REQ-017 AW/W channels: awid, awaddr, awsize, awvalid, wid, wdata, wstrb, wlast, wvalid out; awready, wready in; awlen/awburst/awlock/awcache/awprot constant as on AR.
REQ-018 B channel: bid[3:0], bresp[1:0], bvalid in; bready out.

Function
REQ-019 At most one request across all ports SHALL be accepted per cycle; the grant is round-robin, starting at the pointer and searching upward with wrap from NPORT-1 to 0.
REQ-020 After an accept by port g, the pointer SHALL become g+1 mod NPORT; it is unchanged in cycles with no accept.
REQ-021 sram_addr_ok[g] SHALL be combinational and asserted in the same cycle as sram_req[g] when port g is granted and eligible; no other addr_ok bit is high that cycle.
REQ-022 A read SHALL be eligible when all of the following hold: (arvalid==0 or arready==1), the port's read counter is below RD_OUTS, the port has no write outstanding, and the hazard rule (REQ-031) passes.
REQ-023 A write SHALL be eligible when all of the following hold: no write is outstanding bridge-wide, and the port's read counter is 0.
REQ-024 On an accepted read, the bridge SHALL do the following on the next cycle: assert arvalid, drive araddr=addr, arsize={1'b0,size}, arid=g, and hold them until arready is seen.
REQ-025 rready SHALL be constant 1. An R beat with rid=i SHALL pulse sram_data_ok[i] for one cycle in the same cycle, with sram_rdata[i]=rdata. rresp is ignored.
REQ-026 Per-port read counters SHALL increment on read accept and decrement on R beat; if both occur in the same cycle, the counter is unchanged.
REQ-027 On an accepted write, the bridge SHALL assert awvalid and wvalid on the next cycle, with awid=wid=g, wlast=1, and wdata/wstrb/awaddr/awsize registered.
REQ-028 awvalid and wvalid SHALL each drop independently after their own handshake.
REQ-029 bready SHALL be constant 1. A B beat with bid=i SHALL pulse sram_data_ok[i] for one cycle and clear the write-outstanding state.
REQ-030 When rvalid and bvalid arrive in the same cycle, both SHALL be served (they necessarily target different ports per REQ-022/023).
REQ-031 Hazard rule: see Configuration.

Reset
REQ-032 While reset=1 at a clk edge, the following SHALL be cleared: arvalid=0, awvalid=0, wvalid=0, all counters=0, write-outstanding=0, RR pointer=0, and all addr_ok/data_ok=0.
REQ-033 Reset mid-transaction SHALL abandon all outstanding state; the AXI slave is reset concurrently and responses issued before reset are not tracked.

Configuration
REQ-034 Macro SRAM2AXI_RAW_CHECK_EN.
- Defined: a read SHALL be blocked only when a write is outstanding and araddr[31:2] matches the pending awaddr[31:2].
- Undefined: all reads SHALL be blocked while any write is outstanding.

Verification
REQ-035 Port0 reads 0x1000 with arready=1 and the slave returning rid=0 rdata=0xDEADBEEF 2 cycles later -> addr_ok[0] in the request cycle, arvalid next cycle, then data_ok[0] with rdata0=0xDEADBEEF.
REQ-036 Both ports request reads continuously (NPORT=2) -> grants alternate 0,1,0,1; each port is stalled once its counter reaches RD_OUTS=2 until an R beat returns.
REQ-037 Port1 writes 0x2000 data 0x12345678 wstrb=0xF with awready delayed 3 cycles and wready=1 -> wvalid drops after 1 cycle, awvalid is held 3 cycles, and data_ok[1] is asserted on bvalid with bid=1.
REQ-038 Write pending to 0x3000 while port0 reads 0x3004 -> with the macro, the read is accepted; without it, the read stalls until the B beat; a read of 0x3000 stalls in both builds.
REQ-039 A read beat with rid=0 and a B beat with bid=1 arrive in the same cycle -> data_ok=2'b11.
REQ-040 Reset asserted while arvalid=1 and counter=1 -> the next cycle arvalid=0, the counter is 0, and a new request is accepted immediately.
